// File: rtl/instr_encoder_pkg.sv
//------------------------------------------------------------------------------
// instr_encoder_pkg : shared immediate-type encodings and the reference decoder.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package instr_encoder_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  // Standard RISC-V immediate extraction, used to cross-check the packer.
  function automatic logic [DATA_WIDTH-1:0] imm_decode(input logic [DATA_WIDTH-1:0] x,
                                                       input logic [2:0]            t);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (t)
      IMM_I:   r = {{20{x[31]}}, x[31:20]};
      IMM_S:   r = {{20{x[31]}}, x[31:25], x[11:7]};
      IMM_B:   r = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      IMM_U:   r = {x[31:12], 12'b0};
      IMM_J:   r = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_imm_pack.sv
//------------------------------------------------------------------------------
// instr_encoder_imm_pack : combinational immediate packer with range checks.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [2:0]            type_i,
  input  logic [DATA_WIDTH-1:0] base_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  err_o
);

  logic sext_ok_11, sext_ok_12, sext_ok_20;

  // Upper bits must be pure sign extension of the encodable field.
  assign sext_ok_11 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign sext_ok_12 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign sext_ok_20 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    instr_o = base_i;
    err_o   = 1'b0;
    case (type_i)
      IMM_I: begin
        instr_o[31:20] = imm_i[11:0];
        err_o          = ~sext_ok_11;
      end
      IMM_S: begin
        instr_o[31:25] = imm_i[11:5];
        instr_o[11:7]  = imm_i[4:0];
        err_o          = ~sext_ok_11;
      end
      IMM_B: begin
        instr_o[31]    = imm_i[12];
        instr_o[30:25] = imm_i[10:5];
        instr_o[11:8]  = imm_i[4:1];
        instr_o[7]     = imm_i[11];
        err_o          = ~sext_ok_12 | imm_i[0];
      end
      IMM_U: begin
        instr_o[31:12] = imm_i[31:12];
        err_o          = |imm_i[11:0];
      end
      IMM_J: begin
        instr_o[31]    = imm_i[20];
        instr_o[30:21] = imm_i[10:1];
        instr_o[20]    = imm_i[11];
        instr_o[19:12] = imm_i[19:12];
        err_o          = ~sext_ok_20 | imm_i[0];
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
//------------------------------------------------------------------------------
// instr_encoder : immediate packer on a registered valid/ready stream with skid
// buffer and saturating counters. Optional: INSTR_ENCODER_SELFCHECK_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [2:0]            in_imm_type,
  input  logic [DATA_WIDTH-1:0] in_base,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
`ifdef INSTR_ENCODER_SELFCHECK_EN
  ,
  output logic                  selfcheck_fail
`endif
);

  logic [DATA_WIDTH-1:0] pack_instr;
  logic                  pack_err;

  instr_encoder_imm_pack u_imm_pack (
    .imm_i   (in_imm),
    .type_i  (in_imm_type),
    .base_i  (in_base),
    .instr_o (pack_instr),
    .err_o   (pack_err)
  );

  logic                  in_ready_q;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
  logic                  out_err_q, out_err_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic                  skid_err_q, skid_err_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
`ifdef INSTR_ENCODER_SELFCHECK_EN
  logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic [2:0]            out_type_q, out_type_d, skid_type_q, skid_type_d;
  logic                  fail_q;
`endif

  logic in_hs, out_hs, out_free;
  assign in_hs    = in_valid && in_ready_q;
  assign out_hs   = out_valid_q && out_ready;
  assign out_free = !out_valid_q || out_ready;

  // in_ready tracks skid emptiness, so an input handshake never meets a full skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_err_d   = skid_err_q;
`ifdef INSTR_ENCODER_SELFCHECK_EN
    out_imm_d    = out_imm_q;
    out_type_d   = out_type_q;
    skid_imm_d   = skid_imm_q;
    skid_type_d  = skid_type_q;
`endif
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
`ifdef INSTR_ENCODER_SELFCHECK_EN
        out_imm_d    = skid_imm_q;
        out_type_d   = skid_type_q;
`endif
      end else if (in_hs) begin
        out_valid_d = 1'b1;
        out_instr_d = pack_instr;
        out_err_d   = pack_err;
`ifdef INSTR_ENCODER_SELFCHECK_EN
        out_imm_d   = in_imm;
        out_type_d  = in_imm_type;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_instr_d = pack_instr;
      skid_err_d   = pack_err;
`ifdef INSTR_ENCODER_SELFCHECK_EN
      skid_imm_d   = in_imm;
      skid_type_d  = in_imm_type;
`endif
    end

    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (out_hs && !(&beat_cnt_q)) beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
    if (out_hs && out_err_q && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_err_q   <= 1'b0;
      beat_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      in_ready_q   <= !skid_valid_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_err_q   <= skid_err_d;
      beat_cnt_q   <= beat_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef INSTR_ENCODER_SELFCHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_imm_q   <= '0;
      out_type_q  <= '0;
      skid_imm_q  <= '0;
      skid_type_q <= '0;
      fail_q      <= 1'b0;
    end else begin
      out_imm_q   <= out_imm_d;
      out_type_q  <= out_type_d;
      skid_imm_q  <= skid_imm_d;
      skid_type_q <= skid_type_d;
      if (out_valid_q && !out_err_q && (imm_decode(out_instr_q, out_type_q) != out_imm_q))
        fail_q <= 1'b1;
    end
  end

  assign selfcheck_fail = fail_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign beat_cnt  = beat_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
//------------------------------------------------------------------------------
// tb_instr_encoder : scoreboard bench for instr_encoder with directed vectors.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_imm_type;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] beat_cnt;
  logic [15:0] err_cnt;
`ifdef INSTR_ENCODER_SELFCHECK_EN
  logic        selfcheck_fail;
`endif

  instr_encoder #(.CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm      (in_imm),
    .in_imm_type (in_imm_type),
    .in_base     (in_base),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_err     (out_err),
    .beat_cnt    (beat_cnt),
    .err_cnt     (err_cnt)
`ifdef INSTR_ENCODER_SELFCHECK_EN
    ,
    .selfcheck_fail (selfcheck_fail)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a handshake will complete on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", out_instr, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", out_instr, e.instr);
        chk("sb_err", {31'b0, out_err}, {31'b0, e.err});
      end
    end
  end

  task automatic send(input logic [31:0] imm, input logic [2:0] t, input logic [31:0] base,
                      input logic [31:0] ei, input logic ee);
    exp_q.push_back('{instr: ei, err: ee});
    in_valid    = 1'b1;
    in_imm      = imm;
    in_imm_type = t;
    in_base     = base;
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) chk("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_imm      = '0;
    in_imm_type = '0;
    in_base     = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_beat_cnt", {16'b0, beat_cnt}, 32'd0);
    chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // One-cycle latency on the first beat.
    send(32'hFFFFFFFF, IMM_I, 32'h00000013, 32'hFFF00013, 1'b0);
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_instr", out_instr, 32'hFFF00013);
    send(32'h00000010, IMM_B, 32'h00000063, 32'h00000863, 1'b0);
    send(32'h00000800, IMM_J, 32'h0000006F, 32'h0010006F, 1'b0);
    send(32'h12345000, IMM_U, 32'h00000037, 32'h12345037, 1'b0);
    send(32'h00000800, IMM_I, 32'h00000013, 32'h80000013, 1'b1);
    send(32'hFFFFFFFC, IMM_S, 32'h00002023, 32'hFE002E23, 1'b0);
    send(32'h00000003, IMM_B, 32'h00000063, 32'h00000163, 1'b1);
    send(32'h00000005, 3'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    send(32'h00000001, IMM_U, 32'h00000037, 32'h00000037, 1'b1);
    send(32'hFFFFFFFE, IMM_J, 32'h0000006F, 32'hFFFFF06F, 1'b0);
    drain();
    chk("batch_beat_cnt", {16'b0, beat_cnt}, 32'd10);
    chk("batch_err_cnt", {16'b0, err_cnt}, 32'd4);

    // Backpressure: fill output register and skid, third beat must wait.
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 32'd1; in_imm_type = IMM_I; in_base = 32'h13;
    exp_q.push_back('{instr: 32'h00100013, err: 1'b0});
    @(posedge clk); #1;
    chk("bp_held_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_ready_1", {31'b0, in_ready}, 32'd1);
    in_imm = 32'd2;
    exp_q.push_back('{instr: 32'h00200013, err: 1'b0});
    @(posedge clk); #1;
    chk("bp_ready_skid", {31'b0, in_ready}, 32'd0);
    in_imm = 32'd3;
    exp_q.push_back('{instr: 32'h00300013, err: 1'b0});
    @(posedge clk); #1;
    chk("bp_ready_wait", {31'b0, in_ready}, 32'd0);
    chk("bp_held_instr", out_instr, 32'h00100013);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b2b_valid2", {31'b0, out_valid}, 32'd1);
    chk("bp_ready_free", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b2b_valid3", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", {31'b0, out_valid}, 32'd0);
    chk("bp_beat_cnt", {16'b0, beat_cnt}, 32'd3);
    chk("bp_queue", exp_q.size(), 32'd0);

    // Reset with both registers full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 32'd7; in_imm_type = IMM_I; in_base = 32'h13;
    @(posedge clk); #1;
    in_imm = 32'd8;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_beat", {16'b0, beat_cnt}, 32'd0);
    chk("mid_rst_err", {16'b0, err_cnt}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

    send(32'h00000005, IMM_I, 32'h00000013, 32'h00500013, 1'b0);
    drain();
    chk("final_beat_cnt", {16'b0, beat_cnt}, 32'd1);
`ifdef INSTR_ENCODER_SELFCHECK_EN
    chk("selfcheck_fail", {31'b0, selfcheck_fail}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
